rgb_pwm_driver: RTL and testbench

Downstream stage of the lights selector. Takes the selector's 24-bit `light` colour word and drives three PWM outputs (red, green, blue) for a physical RGB LED. The colour is captured into a shadow register only at PWM frame boundaries, so a colour change never produces a glitched partial frame. Duty per channel is `value/256`.

---
 rtl/rgb_pwm_driver.sv | 72 +++++++
 tb/tb_rgb_pwm_driver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for an RGB LED. The colour word is shadowed at
// frame boundaries so a colour change never truncates or glitches a frame.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        enable,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame_start
);

  localparam int unsigned PRE_W   = 16;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned COLOR_W = 24;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = '1;

  logic [PRE_W-1:0]   pre_cnt, pre_cnt_nxt;
  logic [CNT_W-1:0]   pwm_cnt, pwm_cnt_nxt;
  logic [COLOR_W-1:0] shadow, shadow_nxt;
  logic               pwm_r_nxt, pwm_g_nxt, pwm_b_nxt, frame_start_nxt;
  logic               tick_c, wrap_c;

  // Next-state: disabled holds counters at zero and tracks light into shadow.
  always_comb begin
    pre_cnt_nxt     = '0;
    pwm_cnt_nxt     = '0;
    shadow_nxt      = light;
    pwm_r_nxt       = 1'b0;
    pwm_g_nxt       = 1'b0;
    pwm_b_nxt       = 1'b0;
    frame_start_nxt = 1'b0;
    tick_c          = (pre_cnt == PRE_LAST);
    wrap_c          = tick_c && (pwm_cnt == CNT_LAST);

    if (enable) begin
      pre_cnt_nxt     = tick_c ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt_nxt     = tick_c ? pwm_cnt + CNT_W'(1) : pwm_cnt;
      shadow_nxt      = wrap_c ? light : shadow;
      frame_start_nxt = wrap_c;
      pwm_r_nxt       = (pwm_cnt < shadow[23:16]);
      pwm_g_nxt       = (pwm_cnt < shadow[15:8]);
      pwm_b_nxt       = (pwm_cnt < shadow[7:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      shadow      <= '0;
      pwm_r       <= 1'b0;
      pwm_g       <= 1'b0;
      pwm_b       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt     <= pre_cnt_nxt;
      pwm_cnt     <= pwm_cnt_nxt;
      shadow      <= shadow_nxt;
      pwm_r       <= pwm_r_nxt;
      pwm_g       <= pwm_g_nxt;
      pwm_b       <= pwm_b_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one instance at PRESCALE=4, one at
// PRESCALE=1, duty counted per frame against hand-computed values.
module tb_rgb_pwm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] light, light1;
  logic        enable, enable1;
  logic        pwm_r, pwm_g, pwm_b, frame_start;
  logic        pwm_r1, pwm_g1, pwm_b1, frame_start1;

  int vectors = 0;
  int errors  = 0;
  int cr, cg, cb, cf, cr1, cg1, cb1, cf1;

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .light(light), .enable(enable),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b), .frame_start(frame_start)
  );

  rgb_pwm_driver #(.PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .light(light1), .enable(enable1),
    .pwm_r(pwm_r1), .pwm_g(pwm_g1), .pwm_b(pwm_b1), .frame_start(frame_start1)
  );

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count high cycles of every output over n clock edges.
  task automatic run(input int n);
    cr = 0; cg = 0; cb = 0; cf = 0; cr1 = 0; cg1 = 0; cb1 = 0; cf1 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      cr  += int'(pwm_r);  cg  += int'(pwm_g);  cb  += int'(pwm_b);  cf  += int'(frame_start);
      cr1 += int'(pwm_r1); cg1 += int'(pwm_g1); cb1 += int'(pwm_b1); cf1 += int'(frame_start1);
    end
  endtask

  task automatic check_frame(input string tag, input int er, input int eg, input int eb);
    check({tag, "_r"}, cr, er);
    check({tag, "_g"}, cg, eg);
    check({tag, "_b"}, cb, eb);
    check({tag, "_fs_count"}, cf, 1);
    check({tag, "_fs_end"}, int'(frame_start), 1);
  endtask

  task automatic wait_fs1(input string tag);
    int n = 0;
    while (frame_start1 !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    check(tag, int'(frame_start1), 1);
  endtask

  initial begin
    // 1: reset with full white requested; first frame must be dark
    rst = 1'b0; enable = 1'b1; light = 24'hFFFFFF;
    enable1 = 1'b1; light1 = 24'h010101;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outputs", int'({pwm_r, pwm_g, pwm_b, frame_start}), 0);
    end
    rst = 1'b1;
    run(1023);
    check("first_frame_r", cr, 0);
    check("first_frame_g", cg, 0);
    check("first_frame_b", cb, 0);
    check("first_frame_fs", cf, 0);
    step();
    check("first_wrap_fs", int'(frame_start), 1);
    check("first_wrap_outputs", int'({pwm_r, pwm_g, pwm_b}), 0);

    // White frame (255 each), with blue-only requested for the next one
    light = 24'h0000FF;
    run(1024);
    check_frame("white", 1020, 1020, 1020);

    // 2: blue only
    run(1024);
    check_frame("blue", 0, 0, 1020);
    check("blue_low_at_255", int'(pwm_b), 0);

    // 3: mixed duty; frame C still blue, frame D uses 804000
    light = 24'h804000;
    run(1024);
    check_frame("blue_hold", 0, 0, 1020);
    check("mixed_fs_cycle_rg", int'({pwm_r, pwm_g}), 0);
    step();
    check("mixed_rise", int'({pwm_r, pwm_g, pwm_b}), 3'b110);
    run(1023);
    check_frame("mixed_rest", 511, 255, 0);

    // 4: mid-frame change at pwm_cnt=100
    light = 24'h800000;
    run(1024);
    check_frame("mixed_again", 512, 256, 0);
    run(400);
    begin
      int first_r;
      first_r = cr;
      light = 24'h100000;
      run(624);
      check("midchange_keep_r", first_r + cr, 512);
      check("midchange_fs", int'(frame_start), 1);
    end
    run(1024);
    check_frame("after_change", 64, 0, 0);

    // 5: disable mid-frame, then re-enable with green
    light = 24'h00FF00;
    run(100);
    enable = 1'b0;
    step();
    check("disable_outputs", int'({pwm_r, pwm_g, pwm_b, frame_start}), 0);
    run(5);
    check("disabled_g", cg, 0);
    check("disabled_fs", cf, 0);
    enable = 1'b1;
    step();
    check("enable_first_g", int'(pwm_g), 1);
    check("enable_no_fs", int'(frame_start), 0);
    run(1023);
    check_frame("enable_rest", 0, 1019, 0);

    // 6: PRESCALE=1 instance, 010101 -> one high cycle per channel per frame
    wait_fs1("p1_sync");
    step();
    check("p1_rise", int'({pwm_r1, pwm_g1, pwm_b1}), 3'b111);
    run(255);
    check("p1_r", cr1, 0);
    check("p1_fs_period", int'(frame_start1), 1);
    run(256);
    check("p1_frame_r", cr1, 1);
    check("p1_frame_g", cg1, 1);
    check("p1_frame_b", cb1, 1);
    check("p1_frame_fs", cf1, 1);
    check("p1_frame_fs_end", int'(frame_start1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
